// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory bus between instruction fetch and the
// load/store path. Data normally wins arbitration, but a starvation counter
// hands the bus to fetch after STARVE_LIMIT back-to-back data grants that
// happened while fetch was waiting. Stores are lane-steered with byte strobes,
// loads are sign/zero extended, misaligned or malformed requests are answered
// with an error and no bus cycle, and a memory that never answers is aborted
// after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port (word reads only)
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  output logic        f_err,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // shared memory bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [SCW-1:0] STARVE_MAX   = SCW'(STARVE_LIMIT);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT - 1);

  // RISC-V load/store width encodings (func3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t         state;
  logic [SCW-1:0] starve_cnt;
  logic [TCW-1:0] timeout_cnt;

  // latched view of the request currently owning the bus
  logic           own_fetch;
  logic [2:0]     func3_q;
  logic [1:0]     lane_q;

  // decode of the incoming requests, only meaningful in IDLE
  logic           grant_f;
  logic           grant_d;
  logic           f_illegal;
  logic           d_illegal;
  logic [31:0]    st_wdata;
  logic [3:0]     st_wstrb;

  // load extraction from the returned word
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    load_data;

  // Grant choice, request legality and store lane steering for the IDLE decision
  always_comb begin
    grant_f   = f_req && (!d_req || (starve_cnt == STARVE_MAX));
    grant_d   = d_req && !grant_f;
    f_illegal = (f_addr[1:0] != 2'b00);
    d_illegal = 1'b0;
    st_wdata  = d_wdata;
    st_wstrb  = 4'b0000;
    case (d_func3)
      F3_B: begin
        d_illegal = 1'b0;
        st_wdata  = {4{d_wdata[7:0]}};
        st_wstrb  = 4'b0001 << d_addr[1:0];
      end
      F3_H: begin
        d_illegal = d_addr[0];
        st_wdata  = {2{d_wdata[15:0]}};
        st_wstrb  = 4'b0011 << d_addr[1:0];
      end
      F3_W: begin
        d_illegal = (d_addr[1:0] != 2'b00);
        st_wdata  = d_wdata;
        st_wstrb  = 4'b1111;
      end
      F3_BU: begin
        d_illegal = d_we;
      end
      F3_HU: begin
        d_illegal = d_we | d_addr[0];
      end
      default: begin
        d_illegal = 1'b1;
      end
    endcase
  end

  // Pick the addressed byte/halfword out of the returned word and extend it
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (func3_q)
      F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   load_data = {24'd0, ld_byte};
      F3_HU:   load_data = {16'd0, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Request FSM: grant in IDLE, run the bus cycle in ACCESS, pulse the ack in RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      timeout_cnt <= '0;
      own_fetch   <= 1'b0;
      func3_q     <= '0;
      lane_q      <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      f_ack       <= 1'b0;
      f_rdata     <= '0;
      f_err       <= 1'b0;
      d_ack       <= 1'b0;
      d_rdata     <= '0;
      d_err       <= 1'b0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      f_err <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!f_req) begin
            starve_cnt <= '0;
          end
          if (grant_f) begin
            starve_cnt <= '0;
            own_fetch  <= 1'b1;
            func3_q    <= F3_W;
            lane_q     <= 2'b00;
            if (f_illegal) begin
              f_ack <= 1'b1;
              f_err <= 1'b1;
              state <= RESP;
            end else begin
              mem_req     <= 1'b1;
              mem_we      <= 1'b0;
              mem_addr    <= {f_addr[31:2], 2'b00};
              mem_wdata   <= '0;
              mem_wstrb   <= 4'b0000;
              timeout_cnt <= '0;
              state       <= ACCESS;
            end
          end else if (grant_d) begin
            if (f_req) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
            own_fetch <= 1'b0;
            func3_q   <= d_func3;
            lane_q    <= d_addr[1:0];
            if (d_illegal) begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
              state <= RESP;
            end else begin
              mem_req     <= 1'b1;
              mem_we      <= d_we;
              mem_addr    <= {d_addr[31:2], 2'b00};
              mem_wdata   <= d_we ? st_wdata : 32'd0;
              mem_wstrb   <= d_we ? st_wstrb : 4'b0000;
              timeout_cnt <= '0;
              state       <= ACCESS;
            end
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            if (own_fetch) begin
              f_ack   <= 1'b1;
              f_rdata <= mem_rdata;
            end else begin
              d_ack <= 1'b1;
              if (!mem_we) begin
                d_rdata <= load_data;
              end
            end
            state <= RESP;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            if (own_fetch) begin
              f_ack   <= 1'b1;
              f_err   <= 1'b1;
              f_rdata <= '0;
            end else begin
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end
            state <= RESP;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
